pc_fetch_ctrl: RTL and testbench

Program-counter and fetch sequencer for the multi-cycle RV32I core. It consumes the 2-bit pc_src select from the branch decision logic and the execute-stage operands, then computes and registers the next PC. It drives the instruction-memory request/response handshake and hands each fetched instruction, with its PC, to decode/execute. Execution is non-pipelined: one instruction is in flight at a time.

---
 rtl/pc_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch sequencer for the multi-cycle RV32I core.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
//
// state    | meaning
// st_boot  | one idle cycle after reset release
// st_fetch | request at pc held until imem accepts
// st_wait  | request accepted, waiting for instruction data
// st_exec  | instruction handed to decode, waiting for br_valid
module pc_fetch_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            br_valid,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap
);

  typedef enum logic [1:0] {
    st_boot  = 2'd0,
    st_fetch = 2'd1,
    st_wait  = 2'd2,
    st_exec  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_nxt;
  logic            take_br;
  logic            take_rsp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_boot;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_boot:  state_nxt = st_fetch;
      st_fetch: if (imem_req_ready) state_nxt = st_wait;
      st_wait:  if (imem_rsp_valid) state_nxt = st_exec;
      st_exec:  if (br_valid)       state_nxt = st_fetch;
      default:  state_nxt = st_boot;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (state == st_fetch) imem_req_valid = 1'b1;
  end

  assign take_rsp  = (state == st_wait) && imem_rsp_valid;
  assign take_br   = (state == st_exec) && br_valid;
  assign imem_addr = pc;
  assign pc_plus4  = pc_cur + XLEN'(4);

  // pc_src 3 is reserved and falls through to sequential flow.
  always_comb begin
    target = pc_cur + XLEN'(4);
    case (pc_src)
      2'd1:    target = pc_cur + imm;
      2'd2:    target = (rs1 + imm) & ~XLEN'(1);
      default: target = pc_cur + XLEN'(4);
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (target[1:0] != 2'b00);
  assign pc_nxt     = misaligned ? TRAP_VECTOR : target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       trap <= 1'b0;
    else if (take_br) trap <= misaligned;
    else              trap <= 1'b0;
  end
`else
  logic unused_tgt;
  assign unused_tgt = ^{target[1:0], TRAP_VECTOR};
  assign pc_nxt     = {target[XLEN-1:2], 2'b00};
  assign trap       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      pc_cur      <= RESET_VECTOR;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= take_rsp;
      if (take_rsp) begin
        instr  <= imem_rsp_data;
        pc_cur <= pc;
      end
      if (take_br) pc <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: fetch handshake, next-PC selection,
// stalls, ignored strobes, wrap-around and reset during an outstanding fetch.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        br_valid;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_cur;
  logic [31:0] pc_plus4;
  logic        trap;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .imm            (imm),
    .rs1            (rs1),
    .br_valid       (br_valid),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc_cur         (pc_cur),
    .pc_plus4       (pc_plus4),
    .trap           (trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge in FETCH; returns at the negedge in WAIT.
  task automatic do_fetch(input logic [31:0] exp_addr, input int stall, input bit spur);
    check_eq("req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_eq("req_addr", imem_addr, exp_addr);
    for (int i = 0; i < stall; i++) begin
      imem_rsp_valid = spur && (i == 1);
      imem_rsp_data  = 32'hBAD0_BAD0;
      @(negedge clk);
      check_eq("stall_valid", {31'b0, imem_req_valid}, 32'd1);
      check_eq("stall_addr", imem_addr, exp_addr);
      check_eq("stall_ivalid", {31'b0, instr_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check_eq("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
  endtask

  // Entered at a negedge in WAIT; returns at the first EXEC negedge.
  task automatic do_resp(input logic [31:0] data, input logic [31:0] exp_pc, input bit br_in_wait);
    if (br_in_wait) begin
      br_valid = 1'b1;
      pc_src   = 2'd1;
      imm      = 32'h400;
      @(negedge clk);
      br_valid = 1'b0;
      check_eq("wait_br_req", {31'b0, imem_req_valid}, 32'd0);
      check_eq("wait_br_ivalid", {31'b0, instr_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check_eq("instr_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("instr", instr, data);
    check_eq("pc_cur", pc_cur, exp_pc);
    check_eq("pc_plus4", pc_plus4, exp_pc + 32'd4);
  endtask

  // Entered at an EXEC negedge; returns at the negedge in FETCH.
  task automatic do_exec(input logic [1:0] src, input logic [31:0] immv,
                         input logic [31:0] rs1v, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check_eq("exec_ivalid", {31'b0, instr_valid}, 32'd0);
      check_eq("exec_req", {31'b0, imem_req_valid}, 32'd0);
    end
    pc_src   = src;
    imm      = immv;
    rs1      = rs1v;
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    pc_src         = 2'd0;
    imm            = 32'h0;
    rs1            = 32'h0;
    br_valid       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    repeat (2) @(negedge clk);
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_pc_cur", pc_cur, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_ivalid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_trap", {31'b0, trap}, 32'd0);

    rst_n = 1'b1;
    #1;
    check_eq("boot_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);

    do_fetch(32'h0, 0, 1'b0);
    do_resp(32'h0000_0013, 32'h0, 1'b0);
    do_exec(2'd1, 32'h100, 32'h0, 1);

    do_fetch(32'h100, 0, 1'b0);
    do_resp(32'h1111_1111, 32'h100, 1'b0);
    do_exec(2'd0, 32'h0, 32'h0, 0);

    do_fetch(32'h104, 0, 1'b0);
    do_resp(32'h2222_2222, 32'h104, 1'b0);
    do_exec(2'd1, 32'hFFFF_FFFC, 32'h0, 2);

    do_fetch(32'h100, 0, 1'b0);
    do_resp(32'h3333_3333, 32'h100, 1'b0);
    do_exec(2'd1, 32'hFFFF_FFF8, 32'h0, 0);

    do_fetch(32'hF8, 5, 1'b1);
    do_resp(32'h4444_4444, 32'hF8, 1'b0);
    do_exec(2'd2, 32'h10, 32'h2001, 0);

    do_fetch(32'h2010, 0, 1'b0);
    do_resp(32'h5555_5555, 32'h2010, 1'b1);
    do_exec(2'd3, 32'h7777_0000, 32'h1234_5678, 0);

    do_fetch(32'h2014, 0, 1'b0);
    do_resp(32'h6666_6666, 32'h2014, 1'b0);
    do_exec(2'd2, 32'h0, 32'h40, 0);

    do_fetch(32'h40, 0, 1'b0);
    do_resp(32'h7777_7777, 32'h40, 1'b0);
    do_exec(2'd1, 32'h2, 32'h0, 0);
`ifdef PC_MISALIGN_TRAP_EN
    check_eq("trap_pulse", {31'b0, trap}, 32'd1);
    do_fetch(32'h10, 0, 1'b0);
    check_eq("trap_clear", {31'b0, trap}, 32'd0);
    do_resp(32'h8888_8888, 32'h10, 1'b0);
`else
    check_eq("no_trap", {31'b0, trap}, 32'd0);
    do_fetch(32'h40, 0, 1'b0);
    do_resp(32'h8888_8888, 32'h40, 1'b0);
`endif
    do_exec(2'd2, 32'h0, 32'hFFFF_FFFC, 0);

    do_fetch(32'hFFFF_FFFC, 0, 1'b0);
    do_resp(32'h9999_9999, 32'hFFFF_FFFC, 1'b0);
    check_eq("wrap_plus4", pc_plus4, 32'h0);
    do_exec(2'd0, 32'h0, 32'h0, 0);

    do_fetch(32'h0, 0, 1'b0);
    do_resp(32'hAAAA_AAAA, 32'h0, 1'b0);
    do_exec(2'd1, 32'h80, 32'h0, 0);

    do_fetch(32'h80, 0, 1'b0);
    do_resp(32'hBBBB_BBBB, 32'h80, 1'b0);
    do_exec(2'd0, 32'h0, 32'h0, 0);

    do_fetch(32'h84, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_addr", imem_addr, 32'h0);
    check_eq("mid_rst_pc_cur", pc_cur, 32'h0);
    check_eq("mid_rst_instr", instr, 32'h0);
    check_eq("mid_rst_req", {31'b0, imem_req_valid}, 32'd0);
    check_eq("mid_rst_ivalid", {31'b0, instr_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFEED_FEED;
    #1;
    check_eq("reboot_req", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    check_eq("late_rsp_req", {31'b0, imem_req_valid}, 32'd1);
    check_eq("late_rsp_ivalid", {31'b0, instr_valid}, 32'd0);
    check_eq("late_rsp_instr", instr, 32'h0);
    imem_rsp_valid = 1'b0;

    do_fetch(32'h0, 0, 1'b0);
    do_resp(32'h0000_0013, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
